// File: rtl/regfile_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | regfile_pkg : shared register-file state type and default sizes  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package regfile_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_e;

  localparam int RF_WIDTH = 32;
  localparam int RF_DEPTH = 32;

endpackage
`default_nettype wire

// File: rtl/regfile_mp_bypass_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | regfile_mp_bypass_if : read/write/issue bundle of the reg file   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface regfile_mp_bypass_if
  import regfile_pkg::*;
#(
  parameter int WIDTH = RF_WIDTH,
  parameter int DEPTH = RF_DEPTH,
  parameter int NRD   = 2,
  parameter int NWR   = 1
);
  localparam int AW = $clog2(DEPTH);

  logic                      ready;
  logic [NRD-1:0][AW-1:0]    raddr;
  logic [NRD-1:0][WIDTH-1:0] rdata;
  logic [NRD-1:0]            rbusy;
  logic [NWR-1:0]            we;
  logic [NWR-1:0][AW-1:0]    waddr;
  logic [NWR-1:0][WIDTH-1:0] wdata;
  logic                      issue_en;
  logic [AW-1:0]             issue_addr;

  modport master (
    input  ready, rdata, rbusy,
    output raddr, we, waddr, wdata, issue_en, issue_addr
  );

  modport slave (
    output ready, rdata, rbusy,
    input  raddr, we, waddr, wdata, issue_en, issue_addr
  );

endinterface
`default_nettype wire

// File: rtl/regfile_read_mux.sv
`default_nettype none
// +------------------------------------------------------------------+
// | regfile_read_mux : one read port - zero reg, bypass, busy mask   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module regfile_read_mux #(
  parameter int WIDTH    = 32,
  parameter int AW       = 5,
  parameter int NWR      = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                      run_i,
  input  logic [AW-1:0]             raddr_i,
  input  logic [NWR-1:0]            we_i,
  input  logic [NWR-1:0][AW-1:0]    waddr_i,
  input  logic [NWR-1:0][WIDTH-1:0] wdata_i,
  input  logic [WIDTH-1:0]          rf_data_i,
  input  logic                      busy_i,
  output logic [WIDTH-1:0]          rdata_o,
  output logic                      rbusy_o
);

  logic hit;

  always_comb begin
    rdata_o = rf_data_i;
    hit     = 1'b0;
    // Ascending scan so the highest-index matching write port wins.
    for (int j = 0; j < NWR; j++) begin
      if (we_i[j] && (waddr_i[j] == raddr_i)) begin
        rdata_o = wdata_i[j];
        hit     = 1'b1;
      end
    end
    rbusy_o = busy_i & ~hit;
    if ((ZERO_REG != 0) && (raddr_i == '0)) begin
      rdata_o = '0;
      rbusy_o = 1'b0;
    end
    if (!run_i) begin
      rdata_o = '0;
      rbusy_o = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/regfile_mp_bypass.sv
`default_nettype none
// +------------------------------------------------------------------+
// | regfile_mp_bypass : multi-port register file with write bypass,  |
// | sequenced clear and busy scoreboard.                Rev 1.0      |
// +------------------------------------------------------------------+
module regfile_mp_bypass
  import regfile_pkg::*;
#(
  parameter int WIDTH    = RF_WIDTH,
  parameter int DEPTH    = RF_DEPTH,
  parameter int NRD      = 2,
  parameter int NWR      = 1,
  parameter int ZERO_REG = 1
) (
  input  logic               CLK,
  input  logic               RST,
  regfile_mp_bypass_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  rf_state_e               state_q, state_d;
  logic [AW-1:0]           clr_ptr_q, clr_ptr_d;
  logic                    ready_q, ready_d;
  logic [DEPTH-1:0]        busy_q, busy_d;
  logic [WIDTH-1:0]        rf_q [DEPTH];
  logic                    run;
  logic [NWR-1:0]          wr_en;
  logic [NRD-1:0][WIDTH-1:0] rdata;
  logic [NRD-1:0]          rbusy;

  assign run = (state_q == RUN);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
      ready_q   <= 1'b0;
      busy_q    <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    ready_d   = ready_q;
    case (state_q)
      CLEAR: begin
        clr_ptr_d = clr_ptr_q + AW'(1);
        if (clr_ptr_q == AW'(DEPTH - 1)) begin
          state_d = RUN;
          ready_d = 1'b1;
        end
      end
      RUN:     ;
      default: state_d = CLEAR;
    endcase
  end

  always_comb begin
    for (int j = 0; j < NWR; j++) begin
      wr_en[j] = run & bus.we[j] & ~((ZERO_REG != 0) && (bus.waddr[j] == '0));
    end
  end

  // Clears are applied before the issue so a new producer supersedes a retiring one.
  always_comb begin
    busy_d = busy_q;
    if (run) begin
      for (int j = 0; j < NWR; j++) begin
        if (bus.we[j]) busy_d[bus.waddr[j]] = 1'b0;
      end
      if (bus.issue_en) busy_d[bus.issue_addr] = 1'b1;
    end
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (state_q == CLEAR) begin
        rf_q[clr_ptr_q] <= '0;
      end else begin
        for (int j = 0; j < NWR; j++) begin
          if (wr_en[j]) rf_q[bus.waddr[j]] <= bus.wdata[j];
        end
      end
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd_port
    regfile_read_mux #(
      .WIDTH    (WIDTH),
      .AW       (AW),
      .NWR      (NWR),
      .ZERO_REG (ZERO_REG)
    ) u_read_mux (
      .run_i     (run),
      .raddr_i   (bus.raddr[i]),
      .we_i      (bus.we),
      .waddr_i   (bus.waddr),
      .wdata_i   (bus.wdata),
      .rf_data_i (rf_q[bus.raddr[i]]),
      .busy_i    (busy_q[bus.raddr[i]]),
      .rdata_o   (rdata[i]),
      .rbusy_o   (rbusy[i])
    );
  end

  assign bus.rdata = rdata;
  assign bus.rbusy = rbusy;
  assign bus.ready = ready_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp_bypass.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_regfile_mp_bypass : scoreboard bench for regfile_mp_bypass    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_regfile_mp_bypass;

  localparam int W  = 32;
  localparam int D  = 32;
  localparam int NR = 2;
  localparam int NW = 2;

  typedef struct {
    string       tag;
    int          port;
    logic [31:0] data;
    logic        busy;
  } exp_t;

  logic clk;
  logic rst;

  regfile_mp_bypass_if #(.WIDTH(W), .DEPTH(D), .NRD(NR), .NWR(NW)) rf_bus ();

  regfile_mp_bypass #(
    .WIDTH(W), .DEPTH(D), .NRD(NR), .NWR(NW), .ZERO_REG(1)
  ) u_dut (
    .CLK (clk),
    .RST (rst),
    .bus (rf_bus)
  );

  int          n_chk  = 0;
  int          n_fail = 0;
  exp_t        sb_q[$];
  logic [31:0] m_rf [D];
  logic [D-1:0] m_busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_rd(input string tag, input int p, input logic [31:0] d, input logic b);
    exp_t e;
    e.tag = tag; e.port = p; e.data = d; e.busy = b;
    sb_q.push_back(e);
  endtask

  task automatic idle();
    rf_bus.we       = '0;
    rf_bus.issue_en = 1'b0;
  endtask

  task automatic model_reset();
    for (int a = 0; a < D; a++) m_rf[a] = '0;
    m_busy = '0;
  endtask

  task automatic model_read(input int p, output logic [31:0] d, output logic b);
    logic [4:0] a;
    logic       hit;
    a   = rf_bus.raddr[p];
    hit = 1'b0;
    d   = m_rf[a];
    for (int j = 0; j < NW; j++) begin
      if (rf_bus.we[j] && rf_bus.waddr[j] == a) begin
        d   = rf_bus.wdata[j];
        hit = 1'b1;
      end
    end
    b = m_busy[a] & ~hit;
    if (a == 5'd0) begin
      d = '0;
      b = 1'b0;
    end
  endtask

  task automatic model_update();
    for (int j = 0; j < NW; j++) begin
      if (rf_bus.we[j]) begin
        if (rf_bus.waddr[j] != 5'd0) m_rf[rf_bus.waddr[j]] = rf_bus.wdata[j];
        m_busy[rf_bus.waddr[j]] = 1'b0;
      end
    end
    if (rf_bus.issue_en && rf_bus.issue_addr != 5'd0) m_busy[rf_bus.issue_addr] = 1'b1;
  endtask

  // One RUN cycle: model expectations queued, compared mid-cycle, model advanced on the edge.
  task automatic cyc(input string tag);
    logic [31:0] d;
    logic        b;
    exp_t        e;
    for (int p = 0; p < NR; p++) begin
      model_read(p, d, b);
      expect_rd(tag, p, d, b);
    end
    @(negedge clk);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({e.tag, "_data"}, rf_bus.rdata[e.port], e.data);
      chk({e.tag, "_busy"}, {31'd0, rf_bus.rbusy[e.port]}, {31'd0, e.busy});
    end
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset(input bit wr9, output int cnt);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, rf_bus.ready}, 32'd0);
    rst = 1'b0;
    if (wr9) begin
      rf_bus.we         = 2'b01;
      rf_bus.waddr[0]   = 5'd9;
      rf_bus.wdata[0]   = 32'hAB;
      rf_bus.issue_en   = 1'b1;
      rf_bus.issue_addr = 5'd9;
      rf_bus.raddr[0]   = 5'd9;
      rf_bus.raddr[1]   = 5'd9;
    end
    cnt = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (rf_bus.ready) break;
      if (wr9 && k == 0) begin
        chk("clr_byp_data", rf_bus.rdata[0], 32'd0);
        chk("clr_byp_busy", {31'd0, rf_bus.rbusy[0]}, 32'd0);
      end
      cnt++;
      @(posedge clk);
      #1;
      idle();
    end
    if (rf_bus.ready) begin
      @(posedge clk);
      #1;
    end
    idle();
    model_reset();
  endtask

  initial begin
    int cnt;
    rst               = 1'b1;
    rf_bus.raddr      = '0;
    rf_bus.waddr      = '0;
    rf_bus.wdata      = '0;
    rf_bus.issue_addr = '0;
    idle();
    model_reset();

    do_reset(1'b0, cnt);
    chk("clear_len", cnt, 32);
    chk("ready_after", {31'd0, rf_bus.ready}, 32'd1);

    for (int a = 0; a < D; a += 2) begin
      rf_bus.raddr[0] = 5'(a);
      rf_bus.raddr[1] = 5'(a + 1);
      expect_rd("clr_rd0", 0, 32'd0, 1'b0);
      expect_rd("clr_rd1", 1, 32'd0, 1'b0);
      cyc("sweep");
    end

    rf_bus.we = 2'b01; rf_bus.waddr[0] = 5'd5; rf_bus.wdata[0] = 32'hDEADBEEF;
    rf_bus.raddr[0] = 5'd5;
    expect_rd("byp5", 0, 32'hDEADBEEF, 1'b0);
    cyc("byp5m");
    idle();
    expect_rd("hold5", 0, 32'hDEADBEEF, 1'b0);
    cyc("hold5m");

    rf_bus.we = 2'b01; rf_bus.waddr[0] = 5'd0; rf_bus.wdata[0] = 32'h1234;
    rf_bus.issue_en = 1'b1; rf_bus.issue_addr = 5'd0; rf_bus.raddr[0] = 5'd0;
    expect_rd("zr_wr", 0, 32'd0, 1'b0);
    cyc("zr_wrm");
    idle();
    expect_rd("zr_after", 0, 32'd0, 1'b0);
    cyc("zr_afterm");

    rf_bus.we = 2'b11; rf_bus.waddr[0] = 5'd7; rf_bus.waddr[1] = 5'd7;
    rf_bus.wdata[0] = 32'h11; rf_bus.wdata[1] = 32'h22; rf_bus.raddr[1] = 5'd7;
    expect_rd("dual7", 1, 32'h22, 1'b0);
    cyc("dual7m");
    idle();
    expect_rd("dual7_st", 1, 32'h22, 1'b0);
    cyc("dual7_stm");

    rf_bus.issue_en = 1'b1; rf_bus.issue_addr = 5'd3; rf_bus.raddr[0] = 5'd3;
    expect_rd("iss3", 0, 32'd0, 1'b0);
    cyc("iss3m");
    idle();
    expect_rd("busy3", 0, 32'd0, 1'b1);
    cyc("busy3m");
    rf_bus.we = 2'b01; rf_bus.waddr[0] = 5'd3; rf_bus.wdata[0] = 32'h33;
    expect_rd("mask3", 0, 32'h33, 1'b0);
    cyc("mask3m");
    idle();
    expect_rd("clr3", 0, 32'h33, 1'b0);
    cyc("clr3m");
    rf_bus.we = 2'b10; rf_bus.waddr[1] = 5'd3; rf_bus.wdata[1] = 32'h44;
    rf_bus.issue_en = 1'b1; rf_bus.issue_addr = 5'd3;
    expect_rd("isswr3", 0, 32'h44, 1'b0);
    cyc("isswr3m");
    idle();
    expect_rd("keep3", 0, 32'h44, 1'b1);
    cyc("keep3m");

    for (int n = 0; n < 300; n++) begin
      rf_bus.we         = 2'($urandom_range(0, 3));
      rf_bus.waddr[0]   = 5'($urandom_range(0, 7));
      rf_bus.waddr[1]   = 5'($urandom_range(0, 7));
      rf_bus.wdata[0]   = $urandom;
      rf_bus.wdata[1]   = $urandom;
      rf_bus.issue_en   = 1'($urandom_range(0, 1));
      rf_bus.issue_addr = 5'($urandom_range(0, 7));
      rf_bus.raddr[0]   = 5'($urandom_range(0, 7));
      rf_bus.raddr[1]   = 5'($urandom_range(0, 31));
      cyc("rnd");
    end
    idle();

    rf_bus.we = 2'b01; rf_bus.waddr[0] = 5'd9; rf_bus.wdata[0] = 32'h99;
    cyc("pre9");
    idle();

    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("mid_ready", {31'd0, rf_bus.ready}, 32'd0);
    do_reset(1'b1, cnt);
    chk("restart_len", cnt, 32);

    rf_bus.raddr[0] = 5'd9;
    rf_bus.raddr[1] = 5'd7;
    expect_rd("rst9", 0, 32'd0, 1'b0);
    expect_rd("rst7", 1, 32'd0, 1'b0);
    cyc("postrst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
